// File: rtl/fp_square_seq.sv
// Sequential fp32 squarer: valid/ready operand in, 24-step shift-add significand
// multiply, truncating normalisation, valid/ready result out.
module fp_square_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {IDLE, MUL, PACK, OUT} state_t;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;

    state_t      state_q, state_d;
    logic [7:0]  exp_q, exp_d;
    logic [47:0] mcand_q, mcand_d;
    logic [23:0] mplier_q, mplier_d;
    logic [47:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        special_q, special_d;
    logic [31:0] result_q, result_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic [7:0]  a_exp;
    logic [22:0] a_mant;
    logic [9:0]  e_pack;
    logic [22:0] m_pack;

    assign a_exp  = a_operand[30:23];
    assign a_mant = a_operand[22:0];

    // Biased exponent of the square, two's complement so underflow shows as <= 0.
    assign e_pack = {1'b0, exp_q, 1'b0} - 10'd127 + {9'd0, acc_q[47]};
    assign m_pack = acc_q[47] ? acc_q[46:24] : acc_q[45:23];

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignment so every register samples
        // the pre-edge values of its neighbours.
        if (rst) begin
            state_q   <= IDLE;
            exp_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            special_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            special_q <= special_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first, so no path infers a latch.
        state_d   = state_q;
        exp_d     = exp_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        special_d = special_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_d     = a_exp;
                    mcand_d   = {24'd0, 1'b1, a_mant};
                    mplier_d  = {1'b1, a_mant};
                    acc_d     = '0;
                    cnt_d     = '0;
                    ovf_d     = 1'b0;
                    unf_d     = 1'b0;
                    special_d = (a_exp == 8'hFF) || (a_exp == 8'h00);
                    if (a_exp == 8'hFF) begin
                        result_d = (a_mant != 23'd0) ? QNAN : POS_INF;
                        state_d  = PACK;
                    end else if (a_exp == 8'h00) begin
                        result_d = '0;
                        state_d  = PACK;
                    end else begin
                        state_d  = MUL;
                    end
                end
            end
            MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd23) state_d = PACK;
            end
            PACK: begin
                // Specials already hold their result; PACK only supplies the one-cycle latency.
                if (!special_q) begin
                    if ($signed(e_pack) >= 10'sd255) begin
                        result_d = POS_INF;
                        ovf_d    = 1'b1;
                    end else if ($signed(e_pack) <= 10'sd0) begin
                        result_d = '0;
                        unf_d    = 1'b1;
                    end else begin
                        result_d = {1'b0, e_pack[7:0], m_pack};
                    end
                end
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fp_square_seq.sv
// Scoreboard bench for fp_square_seq: driver pushes model results, negedge monitor
// pops and compares on each result handshake.
module tb_fp_square_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0] sb_q[$];

    fp_square_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_operand (a_operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: {overflow, underflow, result} from real integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a);
        int unsigned     ex;
        longint unsigned m, p, mant;
        longint          e;
        ex = a[30:23];
        if (ex == 255) return {2'b00, (a[22:0] != 0) ? 32'h7FC0_0000 : 32'h7F80_0000};
        if (ex == 0)   return 34'd0;
        m = 64'h80_0000 + a[22:0];
        p = m * m;
        e = 2 * longint'(ex) - 127;
        if (p >= (64'd1 << 47)) begin
            e++;
            mant = (p >> 24) & 64'h7F_FFFF;
        end else begin
            mant = (p >> 23) & 64'h7F_FFFF;
        end
        if (e >= 255) return {2'b10, 32'h7F80_0000};
        if (e <= 0)   return {2'b01, 32'h0000_0000};
        return {2'b00, 1'b0, 8'(e), 23'(mant)};
    endfunction

    function automatic int latency(input logic [31:0] a);
        return (a[30:23] == 8'd0 || a[30:23] == 8'd255) ? 1 : 25;
    endfunction

    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected output: got %h, expected none", result);
            end else begin
                e = sb_q.pop_front();
                check("result", result, e[31:0]);
                check("overflow", {31'd0, overflow}, {31'd0, e[33]});
                check("underflow", {31'd0, underflow}, {31'd0, e[32]});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [31:0] op, input int hold);
        logic [31:0] r0;
        int n;
        in_valid  = 1'b1;
        a_operand = op;
        wait_ready();
        @(posedge clk);
        sb_q.push_back(model(op));
        #1;
        // Junk held on the operand bus while busy must be ignored.
        a_operand = $urandom;
        check("in_ready busy", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, latency(op));
        in_valid = 1'b0;
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("stall result", result, r0);
            check("stall out_valid", {31'd0, out_valid}, 32'd1);
            check("stall in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready after handshake", {31'd0, in_ready}, 32'd1);
        check("out_valid after handshake", {31'd0, out_valid}, 32'd0);
    endtask

    function automatic logic [31:0] rand_op();
        int unsigned k = $urandom_range(0, 9);
        logic [31:0] r = $urandom;
        if (k == 0) r[30:23] = 8'hFF;
        else if (k == 1) r[30:23] = 8'h00;
        else r[30:23] = 8'($urandom_range(1, 254));
        return r;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_operand = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", {31'd0, in_ready}, 32'd1);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset flags", {30'd0, overflow, underflow}, 32'd0);
        rst = 1'b0;

        send(32'h4040_0000, 0);
        send(32'hC000_0000, 0);
        send(32'h4280_0000, 1);
        send(32'h3FFF_FFFF, 0);
        send(32'h7180_0000, 0);
        send(32'h1C80_0000, 0);
        send(32'h7F80_0000, 0);
        send(32'h7FC0_0001, 0);
        send(32'h0000_0000, 0);
        send(32'h0000_1234, 2);
        send(32'hFF80_0000, 0);
        send(32'h4040_0000, 10);

        // Abort an operation on its 12th MUL cycle; nothing may come out for it.
        in_valid  = 1'b1;
        a_operand = 32'h4040_0000;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", {31'd0, in_ready}, 32'd1);
        check("abort out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("abort no output", {31'd0, out_valid}, 32'd0);
        send(32'h3FC0_0000, 0);

        for (int i = 0; i < 40; i++) send(rand_op(), int'($urandom_range(0, 3)));

        repeat (3) @(posedge clk);
        check("scoreboard drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
